rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Single-port arbiter sharing the instruction ROM between the CPU fetch stage and the data-side load path. It replaces the dual-read-port arrangement so the ROM can be mapped to one synchronous read port. Each cycle it grants at most one requester, drives the ROM word address, and returns registered read data one cycle later with a per-side valid strobe. Loads have priority, and a starvation guard bounds fetch wait time.

## Interface
- ROM_AW, 7, ROM word-address width; ROM window = bytes 0 .. 4*2^ROM_AW-1
- STARVE_MAX, 4, max consecutive cycles fetch may be refused while requesting (legal range 1..15)
- clk  in  1  clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; address held stable until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetch data
- if_err  out  1  with if_valid: misaligned or out-of-window access
- ld_req  in  1  load request; address held stable until ld_gnt
- ld_addr  in  32  load byte address
- ld_gnt  out  1  load granted this cycle (combinational)
- ld_valid  out  1  load data valid, one-cycle pulse
- ld_rdata  out  32  load data
- ld_err  out  1  with ld_valid: misaligned or out-of-window access
- rom_a  out  ROM_AW  ROM word index = granted addr[ROM_AW+1:2]; 0 when idle
- rom_q  in  32  ROM read data, combinational from rom_a

## Operation
- Grant rule, evaluated each cycle:
  - Only one request: grant it.
  - Both requesting: grant load, unless starve_cnt == STARVE_MAX, in which case grant fetch.
- starve_cnt (4 bit):
  - +1 on each cycle in which if_req=1 and load is granted.
  - Cleared when fetch is granted or if_req=0.
  - Never exceeds STARVE_MAX.
- Access check on the granted address: error if addr[1:0] != 0 or addr[31:ROM_AW+2] != 0.
  - Error access: rdata register loads 0 and err=1.
  - Otherwise rdata loads rom_q and err=0.
- Response registers:
  - Each side has its own rdata/err register, updated only when that side is granted.
  - The value holds until that side's next grant.
- valid: registered copy of the corresponding gnt. High for exactly one cycle per grant.
- No request queue. An ungranted requester keeps req high; the arbiter never retains a refused request.
- rom_a:
  - Driven from the granted address, also for error accesses (low bits still taken).
  - 0 when no grant.

## Timing
- Reset (clrn=0, asynchronous):
  - if_gnt=ld_gnt=0 (forced low during reset).
  - if_valid=ld_valid=0, if_rdata=ld_rdata=0, if_err=ld_err=0, starve_cnt=0, rom_a=0.
- Latency: grant in cycle N, rdata/err/valid presented in cycle N+1.
- Throughput: one access per cycle total, back-to-back grants to either side permitted.
- Simultaneous grant to both sides never occurs.
- Reset asserted mid-access: the pending valid is dropped, and no response is produced after reset release.
- The first cycle after reset release arbitrates normally.
- Worst-case fetch wait with continuous loads: STARVE_MAX refused cycles, then a grant on cycle STARVE_MAX+1.

## Structure
- Shared package entries:
  - ROM base/window constants.
  - The access-error check as a function: (addr, ROM_AW) -> err.
- Sub-module rom_resp_reg: rdata/err/valid response register, instantiated once for fetch and once for load.
- The grant logic and starve counter stay in the top module.

## Test plan
- Reset then idle: all outputs 0, rom_a=0. Assert and release clrn mid-grant: no valid pulse after release.
- Fetch only, if_addr=0x0,0x4,0x8 on consecutive cycles:
  - if_gnt=1 each cycle.
  - if_valid on the next cycles.
  - if_rdata = rom_q at word 0, 1, 2.
- Both requesting, STARVE_MAX=4, ld_req held 10 cycles:
  - Load granted 4 cycles, fetch on the 5th, starve_cnt back to 0.
  - Pattern repeats.
- Load addr 0x2 (misaligned) then 0x200 (out of window, ROM_AW=7): ld_valid=1, ld_err=1, ld_rdata=0 for both.
- Interleaved: load at 0x30, fetch at 0x34 in alternating cycles:
  - Each side's rdata updates only on its own valid.
  - Other side's rdata holds its previous value.
- if_req dropped while starve_cnt=3: counter clears, and the next contention restarts the count from 0.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and helpers for the single-port instruction ROM arbiter.
package rom_arbiter_pkg;

  // The ROM is mapped at byte address 0. It holds 2^ROM_AW 32-bit words.
  localparam logic [31:0] ROM_BASE = 32'h0000_0000;

  // Width of the fetch starvation counter. It holds STARVE_MAX values up to 15.
  localparam int STARVE_W = 4;

  // Returns the size of the ROM window in bytes for a given word-address width.
  function automatic logic [31:0] rom_window_bytes(input int unsigned rom_aw);
    return 32'd4 << rom_aw;
  endfunction

  // Flags an access as an error when the byte address is not word aligned,
  // or when the address falls outside the ROM window.
  function automatic logic rom_addr_err(input logic [31:0] addr,
                                        input int unsigned rom_aw);
    logic [31:0] offs;
    logic [31:0] hi;
    offs = addr - ROM_BASE;
    hi   = offs >> (rom_aw + 2);
    return (offs[1:0] != 2'b00) || (hi != 32'h0);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundles the fetch port, the load port and the ROM port of the arbiter.
// The master side holds the requesters and the ROM. The slave side is the arbiter.
interface rom_arbiter_if #(parameter int ROM_AW = 7);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              ld_req;
  logic [31:0]       ld_addr;
  logic              ld_gnt;
  logic              ld_valid;
  logic [31:0]       ld_rdata;
  logic              ld_err;

  logic [ROM_AW-1:0] rom_a;
  logic [31:0]       rom_q;

  modport master (
    output if_req, if_addr, ld_req, ld_addr, rom_q,
    input  if_gnt, if_valid, if_rdata, if_err,
    input  ld_gnt, ld_valid, ld_rdata, ld_err, rom_a
  );

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, rom_q,
    output if_gnt, if_valid, if_rdata, if_err,
    output ld_gnt, ld_valid, ld_rdata, ld_err, rom_a
  );
endinterface

// File: rtl/rom_arbiter_resp_reg.sv
// Per-requester response register. It captures the ROM word, or zero on an
// error access, in the cycle that requester is granted. It then presents the
// word with a one-cycle valid strobe. The data and error values hold until the
// next grant to the same requester.
module rom_resp_reg (
  input  logic        clk,
  input  logic        clrn,
  input  logic        gnt,
  input  logic        err_in,
  input  logic [31:0] rdata_in,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err
);

  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Load a new response only on a grant; otherwise hold the last one.
  always_comb begin
    valid_d = gnt;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (gnt) begin
      rdata_d = err_in ? 32'h0 : rdata_in;
      err_d   = err_in;
    end
  end

  // Response state. Reset drops any valid that is still pending.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign valid = valid_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM read port between instruction fetch and loads.
// Loads win a conflict. A starvation counter hands the port to fetch after
// STARVE_MAX consecutive refused fetch cycles.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ROM_AW     = 7,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         clrn,
  rom_arbiter_if.slave bus
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starved;
  logic                if_gnt;
  logic                ld_gnt;
  logic [31:0]         gnt_addr;
  logic                acc_err;

  assign starved = (starve_q == STARVE_W'(STARVE_MAX));

  // Grant selection and ROM address. Grants are gated by clrn so they
  // read low while reset is asserted.
  always_comb begin
    if_gnt   = clrn & bus.if_req & (~bus.ld_req | starved);
    ld_gnt   = clrn & bus.ld_req & ~(bus.if_req & starved);
    gnt_addr = 32'h0;
    if (ld_gnt)
      gnt_addr = bus.ld_addr;
    else if (if_gnt)
      gnt_addr = bus.if_addr;
    acc_err   = rom_addr_err(gnt_addr, ROM_AW);
    bus.rom_a = gnt_addr[ROM_AW+1:2];
  end

  // Count the cycles fetch is refused while it requests. Clear the count
  // once fetch is served or drops its request.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt)
      starve_d = '0;
    else if (ld_gnt && !starved)
      starve_d = starve_q + STARVE_W'(1);
  end

  // Starvation counter state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.ld_gnt = ld_gnt;

  rom_resp_reg u_if_resp (
    .clk      (clk),
    .clrn     (clrn),
    .gnt      (if_gnt),
    .err_in   (acc_err),
    .rdata_in (bus.rom_q),
    .valid    (bus.if_valid),
    .rdata    (bus.if_rdata),
    .err      (bus.if_err)
  );

  rom_resp_reg u_ld_resp (
    .clk      (clk),
    .clrn     (clrn),
    .gnt      (ld_gnt),
    .err_in   (acc_err),
    .rdata_in (bus.rom_q),
    .valid    (bus.ld_valid),
    .rdata    (bus.ld_rdata),
    .err      (bus.ld_err)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
  localparam int AW   = 7;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ROM_AW(AW)) bus ();

  rom_arbiter #(.ROM_AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input int w);
    return 32'h5A00_0000 + 32'(w) * 32'h0000_0101;
  endfunction

  assign bus.rom_q = rom_word(int'(bus.rom_a));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        e_if_gnt;
    logic        e_ld_gnt;
    logic [6:0]  e_rom_a;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_if_err;
    logic        e_ld_valid;
    logic [31:0] e_ld_rdata;
    logic        e_ld_err;
  } vec_t;

  vec_t vt[17];

  // Drive one cycle at the negedge. Check the grant, then after the next
  // edge check that valid follows the grant.
  task automatic cycle(input logic ifr, input logic [31:0] ifa,
                       input logic ldr, input logic [31:0] lda,
                       input logic eig, input logic elg, input string tag);
    @(negedge clk);
    bus.if_req = ifr; bus.if_addr = ifa; bus.ld_req = ldr; bus.ld_addr = lda;
    #1;
    chk({tag, " if_gnt"}, 32'(bus.if_gnt), 32'(eig));
    chk({tag, " ld_gnt"}, 32'(bus.ld_gnt), 32'(elg));
    @(posedge clk); #1;
    chk({tag, " if_valid"}, 32'(bus.if_valid), 32'(eig));
    chk({tag, " ld_valid"}, 32'(bus.ld_valid), 32'(elg));
    if (eig) chk({tag, " if_rdata"}, bus.if_rdata, rom_word(int'(ifa[AW+1:2])));
    if (elg) chk({tag, " ld_rdata"}, bus.ld_rdata, rom_word(int'(lda[AW+1:2])));
  endtask

  initial begin
    vt[0]  = '{0, 32'h0,   0, 32'h0,   0, 0, 7'd0,   0, 32'h0,        0, 0, 32'h0,         0};
    vt[1]  = '{1, 32'h0,   0, 32'h0,   1, 0, 7'd0,   1, rom_word(0),  0, 0, 32'h0,         0};
    vt[2]  = '{1, 32'h4,   0, 32'h0,   1, 0, 7'd1,   1, rom_word(1),  0, 0, 32'h0,         0};
    vt[3]  = '{1, 32'h8,   0, 32'h0,   1, 0, 7'd2,   1, rom_word(2),  0, 0, 32'h0,         0};
    vt[4]  = '{0, 32'h0,   0, 32'h0,   0, 0, 7'd0,   0, rom_word(2),  0, 0, 32'h0,         0};
    vt[5]  = '{0, 32'h0,   1, 32'h2,   0, 1, 7'd0,   0, rom_word(2),  0, 1, 32'h0,         1};
    vt[6]  = '{0, 32'h0,   1, 32'h200, 0, 1, 7'd0,   0, rom_word(2),  0, 1, 32'h0,         1};
    vt[7]  = '{0, 32'h0,   1, 32'h30,  0, 1, 7'd12,  0, rom_word(2),  0, 1, rom_word(12),  0};
    vt[8]  = '{1, 32'h34,  0, 32'h0,   1, 0, 7'd13,  1, rom_word(13), 0, 0, rom_word(12),  0};
    vt[9]  = '{0, 32'h0,   1, 32'h30,  0, 1, 7'd12,  0, rom_word(13), 0, 1, rom_word(12),  0};
    vt[10] = '{1, 32'h34,  0, 32'h0,   1, 0, 7'd13,  1, rom_word(13), 0, 0, rom_word(12),  0};
    vt[11] = '{1, 32'h35,  0, 32'h0,   1, 0, 7'd13,  1, 32'h0,        1, 0, rom_word(12),  0};
    vt[12] = '{0, 32'h0,   1, 32'h1FC, 0, 1, 7'd127, 0, 32'h0,        1, 1, rom_word(127), 0};
    vt[13] = '{1, 32'h10,  1, 32'h20,  0, 1, 7'd8,   0, 32'h0,        1, 1, rom_word(8),   0};
    vt[14] = '{0, 32'h0,   0, 32'h0,   0, 0, 7'd0,   0, 32'h0,        1, 0, rom_word(8),   0};
    vt[15] = '{0, 32'h0,   1, 32'h8000_0010, 0, 1, 7'd4, 0, 32'h0,    1, 1, 32'h0,         1};
    vt[16] = '{0, 32'h0,   0, 32'h0,   0, 0, 7'd0,   0, 32'h0,        1, 0, 32'h0,         1};

    // Reset and idle.
    clrn = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.ld_req = 1'b0; bus.ld_addr = 32'h0;
    #12;
    chk("rst if_gnt",   32'(bus.if_gnt),   32'h0);
    chk("rst ld_gnt",   32'(bus.ld_gnt),   32'h0);
    chk("rst if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst ld_valid", 32'(bus.ld_valid), 32'h0);
    chk("rst if_rdata", bus.if_rdata,      32'h0);
    chk("rst ld_rdata", bus.ld_rdata,      32'h0);
    chk("rst if_err",   32'(bus.if_err),   32'h0);
    chk("rst ld_err",   32'(bus.ld_err),   32'h0);
    chk("rst rom_a",    32'(bus.rom_a),    32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.if_req = vt[i].if_req; bus.if_addr = vt[i].if_addr;
      bus.ld_req = vt[i].ld_req; bus.ld_addr = vt[i].ld_addr;
      #1;
      chk($sformatf("v%0d if_gnt", i), 32'(bus.if_gnt), 32'(vt[i].e_if_gnt));
      chk($sformatf("v%0d ld_gnt", i), 32'(bus.ld_gnt), 32'(vt[i].e_ld_gnt));
      chk($sformatf("v%0d rom_a", i),  32'(bus.rom_a),  32'(vt[i].e_rom_a));
      @(posedge clk); #1;
      chk($sformatf("v%0d if_valid", i), 32'(bus.if_valid), 32'(vt[i].e_if_valid));
      chk($sformatf("v%0d if_rdata", i), bus.if_rdata,      vt[i].e_if_rdata);
      chk($sformatf("v%0d if_err", i),   32'(bus.if_err),   32'(vt[i].e_if_err));
      chk($sformatf("v%0d ld_valid", i), 32'(bus.ld_valid), 32'(vt[i].e_ld_valid));
      chk($sformatf("v%0d ld_rdata", i), bus.ld_rdata,      vt[i].e_ld_rdata);
      chk($sformatf("v%0d ld_err", i),   32'(bus.ld_err),   32'(vt[i].e_ld_err));
    end

    // Continuous contention: four loads, then fetch, repeated.
    for (int c = 0; c < 10; c++) begin
      logic ef;
      ef = ((c % 5) == 4);
      cycle(1'b1, 32'h40, 1'b1, 32'h44, ef, !ef, $sformatf("starve c%0d", c));
    end

    // Fetch drops its request at count 3. The count must restart from 0.
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 32'h48, 1'b1, 32'h4C, 1'b0, 1'b1, $sformatf("drop pre%0d", c));
    cycle(1'b0, 32'h0, 1'b1, 32'h4C, 1'b0, 1'b1, "drop gap");
    for (int c = 0; c < 5; c++) begin
      logic ef;
      ef = (c == 4);
      cycle(1'b1, 32'h48, 1'b1, 32'h4C, ef, !ef, $sformatf("drop post%0d", c));
    end

    // Reset asserted while a grant is live.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h4; bus.ld_req = 1'b0;
    #1;
    chk("midrst gnt before", 32'(bus.if_gnt), 32'h1);
    clrn = 1'b0;
    #1;
    chk("midrst gnt forced", 32'(bus.if_gnt), 32'h0);
    chk("midrst rom_a",      32'(bus.rom_a),  32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
    chk("postrst if_valid", 32'(bus.if_valid), 32'h0);
    chk("postrst ld_valid", 32'(bus.ld_valid), 32'h0);
    chk("postrst if_rdata", bus.if_rdata,      32'h0);
    chk("postrst ld_rdata", bus.ld_rdata,      32'h0);
    @(posedge clk); #1;
    chk("postrst2 if_valid", 32'(bus.if_valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b1, "first after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
